// File: rtl/turn_controller.sv
// turn_controller: two-player turn sequencer.
// It gates the space key to the force bar, captures and clamps the released
// force, issues one launch strobe, waits for landing or timeout, scores hits,
// pauses and then hands the turn over. A game ends when a player reaches the
// win score. A later armed press restarts the game.
module turn_controller #(
  parameter int unsigned MAX_FORCE      = 128,
  parameter int unsigned MIN_FORCE      = 4,
  parameter int unsigned FLIGHT_TIMEOUT = 650_000_000,
  parameter int unsigned SETTLE_CYCLES  = 65_000_000,
  parameter int unsigned WIN_SCORE      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       space,
  input  logic [9:0] force_in,
  input  logic       flight_done,
  input  logic       hit,
  output logic       charge_en,
  output logic       launch,
  output logic [9:0] launch_force,
  output logic       active_player,
  output logic       busy,
  output logic [3:0] score_p0,
  output logic [3:0] score_p1,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    ST_AIM,
    ST_CHARGE,
    ST_CAPTURE,
    ST_FLIGHT,
    ST_SETTLE,
    ST_OVER
  } state_t;

  localparam logic [9:0]  MAX_LVL     = 10'(MAX_FORCE);
  localparam logic [9:0]  MIN_LVL     = 10'(MIN_FORCE);
  localparam logic [3:0]  WIN_LVL     = 4'(WIN_SCORE);
  localparam logic [31:0] FLIGHT_LAST = 32'(FLIGHT_TIMEOUT - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic        armed_q;
  logic [31:0] timer_q;
  logic        launch_q;
  logic [9:0]  launch_force_q;
  logic        active_player_q;
  logic [3:0]  score_p0_q;
  logic [3:0]  score_p1_q;
  logic        game_over_q;
  logic        winner_q;

  // Candidate next values, evaluated every cycle and used by the FSM below
  logic [9:0]  force_clamped_d;
  logic        fumble_d;
  logic [3:0]  score_p0_d;
  logic [3:0]  score_p1_d;
  logic        win_d;

  // Clamp the captured force, flag a fumble, and form saturating score increments
  always_comb begin
    force_clamped_d = (force_in > MAX_LVL) ? MAX_LVL : force_in;
    fumble_d        = (force_clamped_d < MIN_LVL);
    score_p0_d      = (score_p0_q == 4'hF) ? score_p0_q : score_p0_q + 4'd1;
    score_p1_d      = (score_p1_q == 4'hF) ? score_p1_q : score_p1_q + 4'd1;
    win_d           = (score_p0_q >= WIN_LVL) || (score_p1_q >= WIN_LVL);
  end

  // Turn sequencer: state, timer, armed flag and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_AIM;
      armed_q         <= 1'b0;
      timer_q         <= '0;
      launch_q        <= 1'b0;
      launch_force_q  <= '0;
      active_player_q <= 1'b0;
      score_p0_q      <= '0;
      score_p1_q      <= '0;
      game_over_q     <= 1'b0;
      winner_q        <= 1'b0;
    end else begin
      // The launch strobe lasts for a single cycle unless CAPTURE reasserts it
      launch_q <= 1'b0;
      case (state_q)
        ST_AIM: begin
          // A key held over from the previous turn must be released before charging
          if (!space) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= ST_CHARGE;
          end
        end

        ST_CHARGE: begin
          // The force bar latches its value on this same release edge
          if (!space) begin
            armed_q <= 1'b0;
            state_q <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (fumble_d) begin
            state_q <= ST_AIM;
          end else begin
            launch_force_q <= force_clamped_d;
            launch_q       <= 1'b1;
            timer_q        <= '0;
            state_q        <= ST_FLIGHT;
          end
        end

        ST_FLIGHT: begin
          // A landing takes precedence over a timeout in the same cycle
          if (flight_done) begin
            if (hit) begin
              if (active_player_q) begin
                score_p1_q <= score_p1_d;
              end else begin
                score_p0_q <= score_p0_d;
              end
            end
            timer_q <= '0;
            state_q <= ST_SETTLE;
          end else if (timer_q == FLIGHT_LAST) begin
            timer_q <= '0;
            state_q <= ST_SETTLE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end

        ST_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            timer_q <= '0;
            armed_q <= 1'b0;
            if (win_d) begin
              // Only the player who just shot can have crossed the win score
              game_over_q <= 1'b1;
              winner_q    <= active_player_q;
              state_q     <= ST_OVER;
            end else begin
              active_player_q <= ~active_player_q;
              state_q         <= ST_AIM;
            end
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end

        ST_OVER: begin
          // A fresh press after a release restarts the game from player 0
          if (!space) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            score_p0_q      <= '0;
            score_p1_q      <= '0;
            winner_q        <= 1'b0;
            game_over_q     <= 1'b0;
            active_player_q <= 1'b0;
            armed_q         <= 1'b0;
            state_q         <= ST_AIM;
          end
        end

        default: begin
          state_q <= ST_AIM;
        end
      endcase
    end
  end

  // The key reaches the force bar only while the player may charge; rst drops it at once
  assign charge_en = ~rst & space & armed_q &
                     ((state_q == ST_AIM) | (state_q == ST_CHARGE));

  assign busy          = (state_q == ST_FLIGHT) | (state_q == ST_SETTLE);
  assign launch        = launch_q;
  assign launch_force  = launch_force_q;
  assign active_player = active_player_q;
  assign score_p0      = score_p0_q;
  assign score_p1      = score_p1_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule
